// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-master arbiter onto a single memory port.
// One transaction per IDLE/ACCESS/DONE pass; all outputs registered or decoded from state.
module mem_arbiter #(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        m0_req,
    input  logic [29:0] m0_address,
    input  logic [31:0] m0_data_out,
    input  logic [3:0]  m0_data_strobes,
    input  logic        m0_write,
    output logic [31:0] m0_data_in,
    output logic        m0_ack,
    output logic        m0_bus_error,
    output logic        m0_grant,
    input  logic        m1_req,
    input  logic [29:0] m1_address,
    input  logic [31:0] m1_data_out,
    input  logic [3:0]  m1_data_strobes,
    input  logic        m1_write,
    output logic [31:0] m1_data_in,
    output logic        m1_ack,
    output logic        m1_bus_error,
    output logic        m1_grant,
    output logic [29:0] address,
    output logic [31:0] data_out,
    output logic [3:0]  data_strobes,
    output logic        read,
    output logic        write,
    input  logic [31:0] data_in
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    localparam logic [30:0] LIMIT = 31'(MEM_WORDS);
    state_t      state, state_nx;
    logic        last, owner, write_l, err, any_req, pick, sel_write;
    logic [29:0] sel_address;
    logic [31:0] sel_data;
    logic [3:0]  sel_strobes;

    always_comb begin
        state_nx    = state;
        any_req     = m0_req | m1_req;
        pick        = (m0_req & m1_req) ? ~last : m1_req;
        sel_address = pick ? m1_address : m0_address;
        sel_data    = pick ? m1_data_out : m0_data_out;
        sel_strobes = pick ? m1_data_strobes : m0_data_strobes;
        sel_write   = pick ? m1_write : m0_write;
        case (state)
            IDLE:    state_nx = any_req ? ACCESS : IDLE;
            ACCESS:  state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            last         <= 1'b1;
            owner        <= 1'b0;
            write_l      <= 1'b0;
            err          <= 1'b0;
            address      <= '0;
            data_out     <= '0;
            data_strobes <= '0;
            m0_data_in   <= '0;
            m1_data_in   <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && any_req) begin
                owner        <= pick;
                last         <= pick;
                address      <= sel_address;
                data_out     <= sel_data;
                data_strobes <= sel_strobes;
                write_l      <= sel_write;
                err          <= {1'b0, sel_address} >= LIMIT;
            end
            // read data lands on the ACCESS->DONE edge, only for legal reads
            if (state == ACCESS && !write_l && !err) begin
                if (owner) m1_data_in <= data_in;
                else m0_data_in <= data_in;
            end
        end
    end

    assign read         = (state == ACCESS) & ~write_l & ~err;
    assign write        = (state == ACCESS) & write_l & ~err;
    assign m0_ack       = (state == DONE) & ~owner & ~err;
    assign m1_ack       = (state == DONE) & owner & ~err;
    assign m0_bus_error = (state == DONE) & ~owner & err;
    assign m1_bus_error = (state == DONE) & owner & err;
    assign m0_grant     = (state != IDLE) & ~owner;
    assign m1_grant     = (state != IDLE) & owner;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random transactions against a memory model and
// a round-robin transaction-level reference.
module tb_mem_arbiter;
    localparam int MEM_WORDS = 1024;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic [29:0] m0_address = '0, m1_address = '0;
    logic [31:0] m0_data_out = '0, m1_data_out = '0;
    logic [3:0]  m0_data_strobes = '0, m1_data_strobes = '0;
    logic        m0_write = 1'b0, m1_write = 1'b0;
    logic [31:0] m0_data_in, m1_data_in;
    logic        m0_ack, m1_ack, m0_bus_error, m1_bus_error, m0_grant, m1_grant;
    logic [29:0] address;
    logic [31:0] data_out, data_in;
    logic [3:0]  data_strobes;
    logic        read, write;

    logic [31:0] mem [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];
    logic [31:0] exp_din [2];
    logic        last_m;
    logic        mem_clr = 1'b1;
    int          n_cmp = 0;
    int          n_bad = 0;

    mem_arbiter #(.MEM_WORDS(MEM_WORDS)) dut (
        .clock(clock), .reset(reset),
        .m0_req(m0_req), .m0_address(m0_address), .m0_data_out(m0_data_out),
        .m0_data_strobes(m0_data_strobes), .m0_write(m0_write), .m0_data_in(m0_data_in),
        .m0_ack(m0_ack), .m0_bus_error(m0_bus_error), .m0_grant(m0_grant),
        .m1_req(m1_req), .m1_address(m1_address), .m1_data_out(m1_data_out),
        .m1_data_strobes(m1_data_strobes), .m1_write(m1_write), .m1_data_in(m1_data_in),
        .m1_ack(m1_ack), .m1_bus_error(m1_bus_error), .m1_grant(m1_grant),
        .address(address), .data_out(data_out), .data_strobes(data_strobes),
        .read(read), .write(write), .data_in(data_in)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    assign data_in = mem[address[9:0]];
    always @(posedge clock) begin
        if (mem_clr) for (int i = 0; i < MEM_WORDS; i++) mem[i] <= '0;
        else if (write) mem[address[9:0]] <= merge(mem[address[9:0]], data_out, data_strobes);
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_cmd(input int m, input logic wr, input logic [29:0] a, input logic [31:0] d, input logic [3:0] s);
        if (m == 0) begin
            m0_write = wr; m0_address = a; m0_data_out = d; m0_data_strobes = s;
        end else begin
            m1_write = wr; m1_address = a; m1_data_out = d; m1_data_strobes = s;
        end
    endtask

    task automatic do_reset();
        m0_req = 1'b0;
        m1_req = 1'b0;
        reset = 1'b0;
        last_m = 1'b1;
        exp_din[0] = '0;
        exp_din[1] = '0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    // one full transaction starting at an IDLE-cycle negedge
    task automatic step(input logic r0, input logic r1);
        logic        w, wr, ok;
        logic [29:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        chk1("idle_grant0", m0_grant, 1'b0);
        chk1("idle_grant1", m1_grant, 1'b0);
        m0_req = r0;
        m1_req = r1;
        w = (r0 && r1) ? !last_m : r1;
        last_m = w;
        a  = w ? m1_address : m0_address;
        d  = w ? m1_data_out : m0_data_out;
        s  = w ? m1_data_strobes : m0_data_strobes;
        wr = w ? m1_write : m0_write;
        ok = a < 30'(MEM_WORDS);
        @(negedge clock);
        chk1("acc_read", read, !wr && ok);
        chk1("acc_write", write, wr && ok);
        chk32("acc_address", {2'b0, address}, {2'b0, a});
        chk32("acc_strobes", {28'b0, data_strobes}, {28'b0, s});
        if (wr) chk32("acc_data_out", data_out, d);
        chk1("acc_grant0", m0_grant, !w);
        chk1("acc_grant1", m1_grant, w);
        chk1("acc_ack0", m0_ack | m0_bus_error, 1'b0);
        chk1("acc_ack1", m1_ack | m1_bus_error, 1'b0);
        @(negedge clock);
        if (ok && wr) ref_mem[a[9:0]] = merge(ref_mem[a[9:0]], d, s);
        if (ok && !wr) exp_din[w] = ref_mem[a[9:0]];
        chk1("done_ack0", m0_ack, !w && ok);
        chk1("done_err0", m0_bus_error, !w && !ok);
        chk1("done_ack1", m1_ack, w && ok);
        chk1("done_err1", m1_bus_error, w && !ok);
        chk1("done_grant0", m0_grant, !w);
        chk1("done_grant1", m1_grant, w);
        chk32("done_din0", m0_data_in, exp_din[0]);
        chk32("done_din1", m1_data_in, exp_din[1]);
        @(negedge clock);
    endtask

    function automatic logic [29:0] rnd_addr();
        return ($urandom_range(0, 7) == 0) ? 30'(MEM_WORDS + $urandom_range(0, 3)) : 30'($urandom_range(0, 15));
    endfunction

    initial begin
        logic [1:0] r;
        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = '0;
        last_m = 1'b1;
        exp_din[0] = '0;
        exp_din[1] = '0;
        @(negedge clock);
        mem_clr = 1'b0;
        chk1("rst_read", read, 1'b0);
        chk1("rst_write", write, 1'b0);
        chk32("rst_address", {2'b0, address}, 32'h0);
        chk32("rst_data_out", data_out, 32'h0);
        chk32("rst_din0", m0_data_in, 32'h0);
        chk32("rst_din1", m1_data_in, 32'h0);
        chk1("rst_grants", m0_grant | m1_grant, 1'b0);
        chk1("rst_acks", m0_ack | m1_ack | m0_bus_error | m1_bus_error, 1'b0);
        reset = 1'b1;
        @(negedge clock);

        set_cmd(0, 1'b1, 30'd5, 32'hDEADBEEF, 4'hF);
        step(1'b1, 1'b0);
        set_cmd(0, 1'b0, 30'd5, 32'h0, 4'hF);
        step(1'b1, 1'b0);
        m0_req = 1'b0;
        chk32("readback_m0", m0_data_in, 32'hDEADBEEF);

        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_cmd(0, 1'b0, 30'($urandom_range(0, 15)), 32'h0, 4'hF);
            set_cmd(1, 1'b0, 30'($urandom_range(0, 15)), 32'h0, 4'hF);
            step(1'b1, 1'b1);
        end
        m0_req = 1'b0;
        m1_req = 1'b0;

        set_cmd(1, 1'b1, 30'd3, 32'h11223344, 4'hF);
        step(1'b0, 1'b1);
        set_cmd(1, 1'b1, 30'd3, 32'h000000AA, 4'b0001);
        step(1'b0, 1'b1);
        set_cmd(1, 1'b0, 30'd3, 32'h0, 4'hF);
        step(1'b0, 1'b1);
        m1_req = 1'b0;
        chk32("byte_merge", m1_data_in, 32'h112233AA);

        set_cmd(0, 1'b0, 30'(MEM_WORDS), 32'h0, 4'hF);
        step(1'b1, 1'b0);
        m0_req = 1'b0;

        set_cmd(1, 1'b1, 30'd7, 32'h55555555, 4'hF);
        m1_req = 1'b1;
        @(negedge clock);
        chk1("abort_write_before", write, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk1("abort_write_drop", write, 1'b0);
        chk1("abort_grant1", m1_grant, 1'b0);
        chk32("abort_address", {2'b0, address}, 32'h0);
        m1_req = 1'b0;
        last_m = 1'b1;
        exp_din[0] = '0;
        exp_din[1] = '0;
        @(negedge clock);
        chk1("abort_no_ack", m1_ack | m1_bus_error, 1'b0);
        reset = 1'b1;
        @(negedge clock);
        chk1("abort_no_ack_after", m1_ack | m1_bus_error, 1'b0);
        set_cmd(0, 1'b0, 30'd9, 32'h0, 4'hF);
        set_cmd(1, 1'b0, 30'd7, 32'h0, 4'hF);
        step(1'b1, 1'b1);
        chk1("tie_after_reset_m0", last_m, 1'b0);
        step(1'b1, 1'b1);
        m0_req = 1'b0;
        m1_req = 1'b0;
        chk32("abort_word_untouched", m1_data_in, 32'h0);

        set_cmd(0, 1'b0, 30'd5, 32'h0, 4'hF);
        m0_req = 1'b1;
        last_m = 1'b0;
        @(negedge clock);
        chk1("rr_grant0", m0_grant, 1'b1);
        chk32("rr_address", {2'b0, address}, 32'd5);
        m0_req = 1'b0;
        @(negedge clock);
        exp_din[0] = ref_mem[5];
        chk1("rr_ack0", m0_ack, 1'b1);
        chk32("rr_din0", m0_data_in, exp_din[0]);
        set_cmd(0, 1'b0, 30'd3, 32'h0, 4'hF);
        m0_req = 1'b1;
        @(negedge clock);
        step(1'b1, 1'b0);
        m0_req = 1'b0;
        chk32("rr_second_din0", m0_data_in, 32'h112233AA);

        for (int i = 0; i < 24; i++) begin
            set_cmd(0, 1'($urandom), rnd_addr(), $urandom, 4'($urandom));
            set_cmd(1, 1'($urandom), rnd_addr(), $urandom, 4'($urandom));
            r = 2'($urandom_range(1, 3));
            step(r[0], r[1]);
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        @(negedge clock);
        chk1("final_idle", m0_grant | m1_grant, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no completion, required finish before 100000");
        $fatal(1, "watchdog expired");
    end
endmodule
